// File: rtl/sram_resp_pkg.sv
// Shared types for the SRAM pin-protocol responder.
package sram_resp_pkg;

  localparam int DQ_W = 16;

  typedef logic [1:0] byte_mask_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_ACTIVE,
    WR_COMMIT
  } sram_resp_state_e;

endpackage

// File: rtl/sram_resp_mem.sv
// Single-port byte-enabled RAM, synchronous read (read-first), maps to block RAM.
module sram_resp_mem
  import sram_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  i_clk,
  input  byte_mask_t            i_be,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [DQ_W-1:0]       i_wdata,
  output logic [DQ_W-1:0]       o_rdata
);

  logic [DQ_W-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge i_clk) begin
    if (i_be[0]) mem_q[i_addr][7:0]  <= i_wdata[7:0];
    if (i_be[1]) mem_q[i_addr][15:8] <= i_wdata[15:8];
    o_rdata <= mem_q[i_addr];
  end

endmodule

// File: rtl/sram_responder.sv
// Emulates an async 16-bit SRAM (IS61LV25616-style) from block RAM, oversampling the pins.
// Optional SRAM_RESPONDER_STATS_EN adds saturating write/read counters.
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int ADDR_W       = 18,
  parameter int DEPTH_LOG2   = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_sram_addr,
  inout  wire  [DQ_W-1:0]   io_sram_dq,
  input  logic              i_sram_ce_n,
  input  logic              i_sram_we_n,
  input  logic              i_sram_oe_n,
  input  logic              i_sram_lb_n,
  input  logic              i_sram_ub_n,
  output logic              o_oob,
  output logic              o_busy
`ifdef SRAM_RESPONDER_STATS_EN
  ,
  output logic [15:0]       o_wr_cnt,
  output logic [15:0]       o_rd_cnt
`endif
);

  localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY - 1);

  logic [ADDR_W-1:0] addr_q, addr_prev_q, hold_addr_q;
  logic [DQ_W-1:0]   dq_q, hold_data_q, rdata, dout_q, dq_out;
  logic              ce_n_q, we_n_q, oe_n_q, lb_n_q, ub_n_q;
  byte_mask_t        hold_mask_q, ram_be;
  sram_resp_state_e  state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              wr_last_q, oob_q;
  logic              rd, wr, addr_chg, enter_drive, enter_commit, drive_en;
  logic [DEPTH_LOG2-1:0] ram_addr;

  assign rd       = !ce_n_q && !oe_n_q && we_n_q;
  assign wr       = !ce_n_q && !we_n_q;
  assign addr_chg = addr_q != addr_prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (wr) state_d = WR_ACTIVE;
        else if (rd) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      RD_WAIT: begin
        if (wr) state_d = WR_ACTIVE;
        else if (!rd) state_d = IDLE;
        else if (addr_chg) cnt_d = CNT_LOAD;
        else if (cnt_q == 3'd0) begin
          // rdata from a commit cycle is stale; wait one more read
          if (!wr_last_q) state_d = RD_DRIVE;
        end else cnt_d = cnt_q - 3'd1;
      end
      RD_DRIVE: begin
        if (!rd) state_d = IDLE;
        else if (addr_chg) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      WR_ACTIVE: if (!wr) state_d = WR_COMMIT;
      WR_COMMIT: begin
        if (rd) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_LOAD;
        end else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_drive  = (state_q == RD_WAIT) && (state_d == RD_DRIVE);
  assign enter_commit = (state_q == WR_ACTIVE) && (state_d == WR_COMMIT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ce_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      wr_last_q <= 1'b0;
      oob_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ce_n_q    <= i_sram_ce_n;
      we_n_q    <= i_sram_we_n;
      oe_n_q    <= i_sram_oe_n;
      wr_last_q <= state_q == WR_COMMIT;
      oob_q     <= (enter_commit && |hold_addr_q[ADDR_W-1:DEPTH_LOG2]) ||
                   (enter_drive && |addr_q[ADDR_W-1:DEPTH_LOG2]);
    end
  end

  always_ff @(posedge i_clk) begin
    addr_q      <= i_sram_addr;
    addr_prev_q <= addr_q;
    dq_q        <= io_sram_dq;
    lb_n_q      <= i_sram_lb_n;
    ub_n_q      <= i_sram_ub_n;
    if (state_d == WR_ACTIVE) begin
      hold_addr_q <= addr_q;
      hold_data_q <= dq_q;
      hold_mask_q <= {~ub_n_q, ~lb_n_q};
    end
    if (enter_drive) dout_q <= rdata;
  end

  assign ram_addr = (state_q == WR_COMMIT) ? hold_addr_q[DEPTH_LOG2-1:0] : addr_q[DEPTH_LOG2-1:0];
  assign ram_be   = (state_q == WR_COMMIT) ? hold_mask_q : 2'b00;

  sram_resp_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .i_clk   (i_clk),
    .i_be    (ram_be),
    .i_addr  (ram_addr),
    .i_wdata (hold_data_q),
    .o_rdata (rdata)
  );

  // A single deselected lane reads as zero; both deselected returns the whole word.
  assign dq_out[15:8] = (ub_n_q && !lb_n_q) ? 8'h00 : dout_q[15:8];
  assign dq_out[7:0]  = (lb_n_q && !ub_n_q) ? 8'h00 : dout_q[7:0];
  assign drive_en     = (state_q == RD_DRIVE) && rd;
  assign io_sram_dq   = drive_en ? dq_out : 16'hzzzz;

  assign o_oob  = oob_q;
  assign o_busy = state_q != IDLE;

`ifdef SRAM_RESPONDER_STATS_EN
  logic [15:0] wr_cnt_q, rd_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (state_q == WR_COMMIT && hold_mask_q != 2'b00 && wr_cnt_q != 16'hFFFF)
        wr_cnt_q <= wr_cnt_q + 16'd1;
      if (enter_drive && rd_cnt_q != 16'hFFFF)
        rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign o_wr_cnt = wr_cnt_q;
  assign o_rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder; read data is checked through an expected-value queue.
module tb_sram_responder;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] addr = '0;
  logic        ce_n = 1'b1, we_n = 1'b1, oe_n = 1'b1, lb_n = 1'b0, ub_n = 1'b0;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_dq = '0;
  wire  [15:0] sram_dq;
  logic        oob, busy;
`ifdef SRAM_RESPONDER_STATS_EN
  logic [15:0] wr_cnt, rd_cnt;
`endif

  assign sram_dq = tb_drv ? tb_dq : 16'hzzzz;
  wire dq_z = (sram_dq === 16'hzzzz);

  sram_responder dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sram_addr (addr),
    .io_sram_dq  (sram_dq),
    .i_sram_ce_n (ce_n),
    .i_sram_we_n (we_n),
    .i_sram_oe_n (oe_n),
    .i_sram_lb_n (lb_n),
    .i_sram_ub_n (ub_n),
    .o_oob       (oob),
    .o_busy      (busy)
`ifdef SRAM_RESPONDER_STATS_EN
    ,
    .o_wr_cnt    (wr_cnt),
    .o_rd_cnt    (rd_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [15:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Waits (bounded) for the DUT to drive DQ, then pops the expected word.
  task automatic wait_drive(input string tag, input logic [17:0] a);
    for (int n = 0; n < 20 && dq_z; n++) @(negedge clk);
    check({tag, "_driven"}, dq_z, 1'b0);
    check({tag, "_data"}, sram_dq, sb_q.pop_front());
    check({tag, "_oob"}, oob, (a[17:12] != 0));
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic lb, input logic ub);
    int pulses = 0;
    @(posedge clk); #1;
    addr = a; tb_dq = d; tb_drv = 1'b1; lb_n = lb; ub_n = ub;
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
    repeat (5) @(posedge clk);
    #1; we_n = 1'b1; tb_drv = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (oob) pulses++;
    end
    check("wr_oob_pulses", pulses, (a[17:12] != 0) ? 1 : 0);
    check("wr_idle", busy, 1'b0);
  endtask

  task automatic do_read(input logic [17:0] a, input logic lb, input logic ub, input logic [15:0] exp);
    sb_q.push_back(exp);
    @(posedge clk); #1;
    addr = a; lb_n = lb; ub_n = ub; ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
    wait_drive("rd", a);
    @(posedge clk); #1;
    oe_n = 1'b1; ce_n = 1'b1; lb_n = 1'b0; ub_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rd_release_z", dq_z, 1'b1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1; ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; tb_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_oob", oob, 1'b0);
    check("rst_dq_z", dq_z, 1'b1);

    // full write, then read latency measured from oe low
    do_write(18'h00010, 16'hBEEF, 1'b0, 1'b0);
    sb_q.push_back(16'hBEEF);
    @(posedge clk); #1; oe_n = 1'b0;
    for (int k = 1; k <= L + 1; k++) begin
      @(posedge clk); @(negedge clk);
      check("lat_z", dq_z, 1'b1);
    end
    @(posedge clk); @(negedge clk);
    check("lat_driven", dq_z, 1'b0);
    check("lat_data", sram_dq, sb_q.pop_front());
    check("lat_busy", busy, 1'b1);
    @(posedge clk); #1; oe_n = 1'b1; ce_n = 1'b1;
    repeat (2) @(negedge clk);
    check("lat_release_z", dq_z, 1'b1);

    // byte-lane merge and lane-selected reads
    do_write(18'd5, 16'h1234, 1'b0, 1'b0);
    do_write(18'd5, 16'hAB00, 1'b1, 1'b0);
    do_read(18'd5, 1'b0, 1'b0, 16'hAB34);
    do_read(18'd5, 1'b0, 1'b1, 16'h0034);
    do_read(18'd5, 1'b1, 1'b1, 16'hAB34);

    // mask 00 writes nothing
    do_write(18'd5, 16'hFFFF, 1'b1, 1'b1);
    do_read(18'd5, 1'b0, 1'b0, 16'hAB34);

    // reset during WR_ACTIVE discards the write
    @(posedge clk); #1;
    addr = 18'd5; tb_dq = 16'h0000; tb_drv = 1'b1; lb_n = 1'b0; ub_n = 1'b0;
    ce_n = 1'b0; we_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_busy", busy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; we_n = 1'b1; ce_n = 1'b1; tb_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    check("abort_busy_clr", busy, 1'b0);
    check("abort_dq_z", dq_z, 1'b1);
    do_read(18'd5, 1'b0, 1'b0, 16'hAB34);

    // address change mid-read, then we low during read
    do_write(18'd6, 16'h6666, 1'b0, 1'b0);
    sb_q.push_back(16'hAB34);
    @(posedge clk); #1;
    addr = 18'd5; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; lb_n = 1'b0; ub_n = 1'b0;
    wait_drive("chg_a", 18'd5);
    @(posedge clk); #1;
    addr = 18'd6;
    sb_q.push_back(16'h6666);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("chg_z", dq_z, 1'b1);
    check("chg_busy", busy, 1'b1);
    wait_drive("chg_b", 18'd6);
    @(posedge clk); #1;
    we_n = 1'b0; lb_n = 1'b1; ub_n = 1'b1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("we_low_z", dq_z, 1'b1);
    end
    @(posedge clk); #1;
    we_n = 1'b1; ce_n = 1'b1; oe_n = 1'b1; lb_n = 1'b0; ub_n = 1'b0;
    repeat (6) @(negedge clk);
    check("we_low_idle", busy, 1'b0);
    do_read(18'd6, 1'b0, 1'b0, 16'h6666);

    // upper address bits alias and flag oob
    do_write(18'h01003, 16'h5A5A, 1'b0, 1'b0);
    do_read(18'd3, 1'b0, 1'b0, 16'h5A5A);
    do_read(18'h01003, 1'b0, 1'b0, 16'h5A5A);

`ifdef SRAM_RESPONDER_STATS_EN
    pulse_reset();
    @(negedge clk);
    check("stats_wr0", wr_cnt, 16'd0);
    check("stats_rd0", rd_cnt, 16'd0);
    do_write(18'd7, 16'h0007, 1'b0, 1'b0);
    do_write(18'd8, 16'h0008, 1'b0, 1'b0);
    do_write(18'd9, 16'h0009, 1'b0, 1'b0);
    do_read(18'd7, 1'b0, 1'b0, 16'h0007);
    do_read(18'd9, 1'b0, 1'b0, 16'h0009);
    check("stats_wr3", wr_cnt, 16'd3);
    check("stats_rd2", rd_cnt, 16'd2);
    pulse_reset();
    @(negedge clk);
    check("stats_wr_clr", wr_cnt, 16'd0);
    check("stats_rd_clr", rd_cnt, 16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
